// File: rtl/phys_reg_free_list_pkg.sv
// Shared core package: physical register file geometry and the physical tag
// type used by rename, ROB, reservation stations, LSQ and the free list.
package phys_reg_free_list_pkg;

    localparam int NUM_PHYS      = 64;               // physical registers, power of two
    localparam int NUM_ARCH      = 32;               // architectural registers, mapped at reset
    localparam int TAG_W         = $clog2(NUM_PHYS); // width of a physical tag
    localparam int NUM_FREE_INIT = NUM_PHYS - NUM_ARCH;

    typedef logic [TAG_W-1:0] phys_tag_t;

    // Occupancy limit, expressed in the width of the count register.
    localparam logic [TAG_W:0] COUNT_MAX = (TAG_W+1)'(NUM_PHYS);

    // Tags NUM_ARCH..NUM_PHYS-1 start in the list; 0..NUM_ARCH-1 are mapped.
    localparam logic [NUM_PHYS-1:0] IN_LIST_INIT =
        {{NUM_FREE_INIT{1'b1}}, {NUM_ARCH{1'b0}}};

endpackage

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list
// Circular free list of physical register tags. Supplies one tag per cycle
// to rename (show-ahead at the head) and accepts up to two tags per cycle
// from ROB retirement.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   alloc_req                  rename consumes alloc_tag this cycle
//   alloc_valid, alloc_tag     head of list; alloc_tag is 0 when empty
//   free_0_valid/free_0_tag    retire slot 0 released tag
//   free_1_valid/free_1_tag    retire slot 1 released tag
//   free_count                 number of tags currently in the list
//   err_double_free            sticky: duplicate or already-listed tag freed
//   err_underflow              sticky: alloc_req while list empty
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             free_0_valid,
    input  logic [TAG_W-1:0] free_0_tag,
    input  logic             free_1_valid,
    input  logic [TAG_W-1:0] free_1_tag,
    output logic [TAG_W:0]   free_count,
    output logic             err_double_free,
    output logic             err_underflow
);

    phys_tag_t           r_entries [NUM_PHYS];
    phys_tag_t           r_head;
    phys_tag_t           r_tail;
    logic [TAG_W:0]      r_count;
    logic [NUM_PHYS-1:0] r_in_list;
    logic                r_err_double_free;
    logic                r_err_underflow;

    logic                w_alloc_valid;
    phys_tag_t           w_head_tag;
    logic                w_pop;
    logic [NUM_PHYS-1:0] w_pop_mask;
    logic [NUM_PHYS-1:0] w_set_mask;
    logic [NUM_PHYS-1:0] w_in_list_eff;
    logic [TAG_W:0]      w_base_count;
    logic                w_acc0;
    logic                w_acc1;
    logic                w_rej0;
    logic                w_rej1;
    phys_tag_t           w_slot1_idx;
    phys_tag_t           w_tail_next;
    logic [TAG_W:0]      w_count_next;

    // A free is taken when the slot is valid, the tag is not the hardwired
    // zero register, the tag is not already listed, it does not duplicate
    // slot 0, and there is room for it.
    function automatic logic free_accept(
        input logic                valid,
        input phys_tag_t           tag,
        input logic [NUM_PHYS-1:0] in_list,
        input logic                dup,
        input logic                room
    );
        return valid && (tag != '0) && !in_list[tag] && !dup && room;
    endfunction

    assign w_alloc_valid = (r_count != '0);
    assign w_head_tag    = r_entries[r_head];
    assign w_pop         = alloc_req && w_alloc_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHYS; gi++) begin : g_masks
            assign w_pop_mask[gi] = w_pop && (w_head_tag == TAG_W'(gi));
            assign w_set_mask[gi] = (w_acc0 && (free_0_tag == TAG_W'(gi))) ||
                                    (w_acc1 && (free_1_tag == TAG_W'(gi)));
        end
    endgenerate

    // The tag leaving the head this cycle no longer counts as listed, so the
    // ROB may legally free it in the same cycle; it is re-appended at tail.
    assign w_in_list_eff = r_in_list & ~w_pop_mask;
    assign w_base_count  = r_count - (TAG_W+1)'(w_pop);

    assign w_acc0 = free_accept(free_0_valid, free_0_tag, w_in_list_eff,
                                1'b0, w_base_count < COUNT_MAX);
    assign w_acc1 = free_accept(free_1_valid, free_1_tag, w_in_list_eff,
                                w_acc0 && (free_1_tag == free_0_tag),
                                (w_base_count + (TAG_W+1)'(w_acc0)) < COUNT_MAX);

    // Tag 0 is dropped silently; any other valid free not taken is an error.
    assign w_rej0 = free_0_valid && (free_0_tag != '0) && !w_acc0;
    assign w_rej1 = free_1_valid && (free_1_tag != '0) && !w_acc1;

    assign w_slot1_idx  = w_acc0 ? (r_tail + TAG_W'(1)) : r_tail;
    assign w_tail_next  = r_tail + TAG_W'(w_acc0) + TAG_W'(w_acc1);
    assign w_count_next = w_base_count + (TAG_W+1)'(w_acc0) + (TAG_W+1)'(w_acc1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                r_entries[i] <= (i < NUM_FREE_INIT) ? TAG_W'(NUM_ARCH + i) : '0;
            end
        end else begin
            if (w_acc0) r_entries[r_tail]      <= free_0_tag;
            if (w_acc1) r_entries[w_slot1_idx] <= free_1_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head            <= '0;
            r_tail            <= TAG_W'(NUM_FREE_INIT);
            r_count           <= (TAG_W+1)'(NUM_FREE_INIT);
            r_in_list         <= IN_LIST_INIT;
            r_err_double_free <= 1'b0;
            r_err_underflow   <= 1'b0;
        end else begin
            if (w_pop) r_head <= r_head + TAG_W'(1);
            r_tail    <= w_tail_next;
            r_count   <= w_count_next;
            // Setting wins over clearing: a popped tag freed the same cycle
            // is back in the list.
            r_in_list <= (r_in_list & ~w_pop_mask) | w_set_mask;
            if (w_rej0 || w_rej1)              r_err_double_free <= 1'b1;
            if (alloc_req && !w_alloc_valid)   r_err_underflow   <= 1'b1;
        end
    end

    assign alloc_valid     = w_alloc_valid;
    assign alloc_tag       = w_alloc_valid ? w_head_tag : '0;
    assign free_count      = r_count;
    assign err_double_free = r_err_double_free;
    assign err_underflow   = r_err_underflow;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Testbench for phys_reg_free_list: a queue-based model of the free list is
// stepped alongside the DUT and compared on every cycle, with literal
// expectations at the key points of each directed scenario.
module tb_phys_reg_free_list;
    import phys_reg_free_list_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             alloc_req = 1'b0;
    logic             alloc_valid;
    logic [TAG_W-1:0] alloc_tag;
    logic             free_0_valid = 1'b0;
    logic [TAG_W-1:0] free_0_tag = '0;
    logic             free_1_valid = 1'b0;
    logic [TAG_W-1:0] free_1_tag = '0;
    logic [TAG_W:0]   free_count;
    logic             err_double_free;
    logic             err_underflow;

    int tests = 0;
    int fails = 0;

    // Model state: the list as a FIFO of tag numbers plus sticky flags.
    int q[$];
    bit m_err_df;
    bit m_err_uf;

    phys_reg_free_list dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_req       (alloc_req),
        .alloc_valid     (alloc_valid),
        .alloc_tag       (alloc_tag),
        .free_0_valid    (free_0_valid),
        .free_0_tag      (free_0_tag),
        .free_1_valid    (free_1_valid),
        .free_1_tag      (free_1_tag),
        .free_count      (free_count),
        .err_double_free (err_double_free),
        .err_underflow   (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit listed(input int t);
        foreach (q[k]) if (q[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int t = NUM_ARCH; t < NUM_PHYS; t++) q.push_back(t);
        m_err_df = 1'b0;
        m_err_uf = 1'b0;
    endtask

    task automatic model_free(input bit v, input int t);
        if (!v || t == 0) return;
        if (listed(t) || q.size() >= NUM_PHYS) m_err_df = 1'b1;
        else q.push_back(t);
    endtask

    // Pop first, then slot 0, then slot 1: a duplicate in slot 1 is then
    // caught simply because slot 0 already put it in the list.
    task automatic model_step(input bit req, input bit v0, input int t0,
                              input bit v1, input int t1);
        if (req) begin
            if (q.size() == 0) m_err_uf = 1'b1;
            else void'(q.pop_front());
        end
        model_free(v0, t0);
        model_free(v1, t1);
    endtask

    task automatic compare_model();
        int exp_tag;
        exp_tag = (q.size() != 0) ? q[0] : 0;
        chk("model alloc_valid", int'(alloc_valid), int'(q.size() != 0));
        chk("model alloc_tag", int'(alloc_tag), exp_tag);
        chk("model free_count", int'(free_count), q.size());
        chk("model err_double_free", int'(err_double_free), int'(m_err_df));
        chk("model err_underflow", int'(err_underflow), int'(m_err_uf));
    endtask

    // One transaction: drive at the falling edge, sampled at the rising edge,
    // checked at the next falling edge.
    task automatic cyc(input bit req, input bit v0, input int t0,
                       input bit v1, input int t1);
        alloc_req    = req;
        free_0_valid = v0;
        free_0_tag   = TAG_W'(t0);
        free_1_valid = v1;
        free_1_tag   = TAG_W'(t1);
        model_step(req, v0, t0, v1, t1);
        @(posedge clk);
        #1;
        alloc_req    = 1'b0;
        free_0_valid = 1'b0;
        free_1_valid = 1'b0;
        @(negedge clk);
        $display("[TB] req=%0d f0=%0d:%0d f1=%0d:%0d -> valid=%0d tag=%0d count=%0d df=%0d uf=%0d",
                 req, v0, t0, v1, t1, alloc_valid, alloc_tag, free_count,
                 err_double_free, err_underflow);
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #2;
        compare_model();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        // Reset state.
        chk("reset alloc_valid", int'(alloc_valid), 1);
        chk("reset alloc_tag", int'(alloc_tag), 32);
        chk("reset free_count", int'(free_count), 32);
        chk("reset err_double_free", int'(err_double_free), 0);
        chk("reset err_underflow", int'(err_underflow), 0);

        // Drain the list: tags 32..63 in order, then empty, then underflow.
        for (int i = 0; i < 32; i++) begin
            chk("drain tag order", int'(alloc_tag), 32 + i);
            cyc(1, 0, 0, 0, 0);
        end
        chk("empty alloc_valid", int'(alloc_valid), 0);
        chk("empty alloc_tag", int'(alloc_tag), 0);
        chk("empty free_count", int'(free_count), 0);
        cyc(1, 0, 0, 0, 0);
        chk("underflow flag", int'(err_underflow), 1);
        chk("underflow count", int'(free_count), 0);

        // Two frees into an empty list become allocatable next cycle.
        cyc(0, 1, 40, 1, 35);
        chk("refill head", int'(alloc_tag), 40);
        chk("refill count", int'(free_count), 2);
        cyc(1, 0, 0, 0, 0);
        chk("refill second", int'(alloc_tag), 35);

        // Pop and free together: count unchanged, freed tag queued at tail.
        do_reset();
        cyc(1, 1, 5, 0, 0);
        chk("popfree head", int'(alloc_tag), 33);
        chk("popfree count", int'(free_count), 32);
        for (int i = 0; i < 31; i++) cyc(1, 0, 0, 0, 0);
        chk("popfree tail tag", int'(alloc_tag), 5);
        chk("popfree tail count", int'(free_count), 1);

        // Same tag on both slots: one copy, error raised.
        do_reset();
        cyc(0, 1, 7, 1, 7);
        chk("dup count", int'(free_count), 33);
        chk("dup flag", int'(err_double_free), 1);

        // Freeing a tag already in the list.
        do_reset();
        cyc(0, 1, 40, 0, 0);
        chk("listed count", int'(free_count), 32);
        chk("listed flag", int'(err_double_free), 1);

        // Tag 0 silently ignored, slot 1 still accepted.
        do_reset();
        cyc(0, 1, 0, 1, 9);
        chk("p0 count", int'(free_count), 33);
        chk("p0 no flag", int'(err_double_free), 0);
        for (int i = 0; i < 32; i++) cyc(1, 0, 0, 0, 0);
        chk("p0 slot1 tag", int'(alloc_tag), 9);

        // Full throughput: one alloc and two frees per cycle, including a
        // free of the very tag being popped.
        do_reset();
        cyc(1, 1, 32, 0, 0);
        chk("self free count", int'(free_count), 32);
        for (int i = 0; i < 15; i++) cyc(1, 1, 2 * i + 1, 1, 2 * i + 2);
        chk("throughput count", int'(free_count), 47);

        // Asynchronous reset in the middle of active traffic.
        alloc_req    = 1'b1;
        free_0_valid = 1'b1;
        free_0_tag   = TAG_W'(31);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("midreset alloc_tag", int'(alloc_tag), 32);
        chk("midreset free_count", int'(free_count), 32);
        chk("midreset alloc_valid", int'(alloc_valid), 1);
        compare_model();
        alloc_req    = 1'b0;
        free_0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 0, 0, 0, 0);
        chk("post reset head", int'(alloc_tag), 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
